// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: stalls, flushes, operand
// forwarding, data-memory wait/timeout tracking and stall/flush counters.
module hazard_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 255
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       de_rs1,
   input  logic [4:0]       de_rs2,
   input  logic             de_uses_rs1,
   input  logic             de_uses_rs2,
   input  logic [4:0]       ex_rs1,
   input  logic [4:0]       ex_rs2,
   input  logic [4:0]       ex_rd,
   input  logic             ex_reg_write,
   input  logic [1:0]       ex_ru_data_src,
   input  logic [4:0]       mem_rd,
   input  logic             mem_reg_write,
   input  logic [4:0]       wb_rd,
   input  logic             wb_reg_write,
   input  logic             ex_br_taken,
   input  logic             dm_req,
   input  logic             dm_ack,
   output logic             pc_stall,
   output logic             if_de_stall,
   output logic             if_de_flush,
   output logic             de_ex_stall,
   output logic             de_ex_flush,
   output logic             ex_mem_stall,
   output logic             mem_wb_flush,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] ST_RUN      = 2'b00;
   localparam logic [1:0] ST_MEM_WAIT = 2'b01;
   localparam logic [1:0] ST_HALT     = 2'b10;

   localparam logic [1:0] SRC_LOAD = 2'b01;
   localparam logic [1:0] FWD_RS   = 2'b00;
   localparam logic [1:0] FWD_MEM  = 2'b01;
   localparam logic [1:0] FWD_WB   = 2'b10;

   localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
   localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

   logic [1:0]        state_q,       state_d;
   logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q,   stall_cnt_d;
   logic [CNT_W-1:0]  flush_cnt_q,   flush_cnt_d;
   logic              mem_timeout_q, mem_timeout_d;

   logic mem_wait_c;
   logic load_use_c;
   logic hold_c;
   logic br_flush_c;
   logic lu_stall_c;

   // Operand source select; MEM result is younger so it wins over WB.
   function automatic logic [1:0] fwd_pick(
      input logic [4:0] rs,
      input logic [4:0] m_rd,
      input logic       m_we,
      input logic [4:0] w_rd,
      input logic       w_we
   );
      logic [1:0] sel;
      sel = FWD_RS;
      if (m_we && (m_rd != 5'd0) && (m_rd == rs)) begin
         sel = FWD_MEM;
      end else if (w_we && (w_rd != 5'd0) && (w_rd == rs)) begin
         sel = FWD_WB;
      end
      return sel;
   endfunction

   always_comb begin
      mem_wait_c = dm_req && !dm_ack;
      load_use_c = (ex_ru_data_src == SRC_LOAD) && ex_reg_write && (ex_rd != 5'd0) &&
                   ((de_uses_rs1 && (de_rs1 == ex_rd)) ||
                    (de_uses_rs2 && (de_rs2 == ex_rd)));
   end

   // Next-state and hazard decisions; memory wait > branch flush > load-use.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      mem_timeout_d = mem_timeout_q;
      hold_c        = 1'b0;
      br_flush_c    = 1'b0;
      lu_stall_c    = 1'b0;

      case (state_q)
         ST_RUN: begin
            if (mem_wait_c) begin
               hold_c     = 1'b1;
               state_d    = ST_MEM_WAIT;
               wait_cnt_d = WAIT_W'(1);
            end else if (ex_br_taken) begin
               br_flush_c = 1'b1;
            end else if (load_use_c) begin
               lu_stall_c = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // A branch parked in EX is handled once we are back in RUN.
            if (dm_ack) begin
               state_d    = ST_RUN;
               wait_cnt_d = '0;
            end else begin
               hold_c = 1'b1;
               if (wait_cnt_q == WAIT_LIMIT) begin
                  state_d       = ST_HALT;
                  mem_timeout_d = 1'b1;
               end else begin
                  wait_cnt_d = wait_cnt_q + WAIT_W'(1);
               end
            end
         end
         ST_HALT: begin
            hold_c        = 1'b1;
            mem_timeout_d = 1'b1;
         end
         default: begin
            state_d    = ST_RUN;
            wait_cnt_d = '0;
         end
      endcase
   end

   // Pipeline controls are combinational and forced idle while in reset.
   always_comb begin
      pc_stall     = rst_n && (hold_c || lu_stall_c);
      if_de_stall  = rst_n && (hold_c || lu_stall_c);
      if_de_flush  = rst_n && br_flush_c;
      de_ex_stall  = rst_n && hold_c;
      de_ex_flush  = rst_n && (br_flush_c || lu_stall_c);
      ex_mem_stall = rst_n && hold_c;
      mem_wb_flush = rst_n && hold_c;
      fwd_a_sel    = rst_n ? fwd_pick(ex_rs1, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : FWD_RS;
      fwd_b_sel    = rst_n ? fwd_pick(ex_rs2, mem_rd, mem_reg_write, wb_rd, wb_reg_write) : FWD_RS;
   end

   // Saturating performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (pc_stall && (stall_cnt_q != CNT_MAX)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
      if (if_de_flush && (flush_cnt_q != CNT_MAX)) begin
         flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RUN;
         wait_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         flush_cnt_q   <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         flush_cnt_q   <= flush_cnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   always_comb begin
      stall_cnt   = stall_cnt_q;
      flush_cnt   = flush_cnt_q;
      mem_timeout = mem_timeout_q;
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: expected per-cycle controls are queued as
// stimulus is applied and compared before the next rising edge.
module tb_hazard_ctrl;

   localparam int unsigned CNT_W       = 4;
   localparam int unsigned MEM_TIMEOUT = 8;
   localparam int unsigned CNT_MAX     = (1 << CNT_W) - 1;

   // {pc_stall, if_de_stall, if_de_flush, de_ex_stall, de_ex_flush, ex_mem_stall, mem_wb_flush}
   localparam logic [6:0] C_NONE = 7'b0000000;
   localparam logic [6:0] C_MW   = 7'b1101011;
   localparam logic [6:0] C_BR   = 7'b0010100;
   localparam logic [6:0] C_LU   = 7'b1100100;

   typedef struct packed {
      logic [6:0] ctl;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       mto;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n;
   logic [4:0] de_rs1, de_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
   logic de_uses_rs1, de_uses_rs2, ex_reg_write, mem_reg_write, wb_reg_write;
   logic [1:0] ex_ru_data_src;
   logic ex_br_taken, dm_req, dm_ack;
   logic pc_stall, if_de_stall, if_de_flush, de_ex_stall, de_ex_flush;
   logic ex_mem_stall, mem_wb_flush, mem_timeout;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [6:0] got_ctl;

   exp_t exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;
   int unsigned exp_stall = 0;
   int unsigned exp_flush = 0;

   hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .de_rs1(de_rs1), .de_rs2(de_rs2), .de_uses_rs1(de_uses_rs1), .de_uses_rs2(de_uses_rs2),
      .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_ru_data_src(ex_ru_data_src), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
      .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .ex_br_taken(ex_br_taken),
      .dm_req(dm_req), .dm_ack(dm_ack),
      .pc_stall(pc_stall), .if_de_stall(if_de_stall), .if_de_flush(if_de_flush),
      .de_ex_stall(de_ex_stall), .de_ex_flush(de_ex_flush), .ex_mem_stall(ex_mem_stall),
      .mem_wb_flush(mem_wb_flush), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
   );

   always #5 clk = ~clk;

   assign got_ctl = {pc_stall, if_de_stall, if_de_flush, de_ex_stall,
                     de_ex_flush, ex_mem_stall, mem_wb_flush};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic clear_inputs();
      de_rs1 = '0; de_rs2 = '0; de_uses_rs1 = 1'b0; de_uses_rs2 = 1'b0;
      ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; ex_reg_write = 1'b0; ex_ru_data_src = 2'b00;
      mem_rd = '0; mem_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
      ex_br_taken = 1'b0; dm_req = 1'b0; dm_ack = 1'b0;
   endtask

   task automatic set_load_use();
      ex_rd = 5'd3; ex_reg_write = 1'b1; ex_ru_data_src = 2'b01;
      de_rs1 = 5'd1; de_uses_rs1 = 1'b1; de_rs2 = 5'd3; de_uses_rs2 = 1'b1;
   endtask

   // Called at a falling edge with inputs already applied.
   task automatic step(input string tag, input logic [6:0] ctl, input logic [1:0] fa,
                       input logic [1:0] fb, input logic mto);
      exp_t e;
      e.ctl = ctl; e.fa = fa; e.fb = fb; e.mto = mto;
      exp_q.push_back(e);
      #2;
      check({tag, ".sb_depth"}, 32'(exp_q.size()), 32'd1);
      e = exp_q.pop_front();
      check({tag, ".ctl"},   32'(got_ctl),     32'(e.ctl));
      check({tag, ".fwd_a"}, 32'(fwd_a_sel),   32'(e.fa));
      check({tag, ".fwd_b"}, 32'(fwd_b_sel),   32'(e.fb));
      check({tag, ".mto"},   32'(mem_timeout), 32'(e.mto));
      check({tag, ".scnt"},  32'(stall_cnt),   exp_stall);
      check({tag, ".fcnt"},  32'(flush_cnt),   exp_flush);
      if (e.ctl[6] && exp_stall < CNT_MAX) exp_stall++;
      if (e.ctl[4] && exp_flush < CNT_MAX) exp_flush++;
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      check({tag, ".ctl"},   32'(got_ctl),     32'd0);
      check({tag, ".fwd_a"}, 32'(fwd_a_sel),   32'd0);
      check({tag, ".fwd_b"}, 32'(fwd_b_sel),   32'd0);
      check({tag, ".mto"},   32'(mem_timeout), 32'd0);
      check({tag, ".scnt"},  32'(stall_cnt),   32'd0);
      check({tag, ".fcnt"},  32'(flush_cnt),   32'd0);
   endtask

   initial begin
      clear_inputs();
      rst_n = 1'b0;
      dm_req = 1'b1;
      #7;
      check_reset("por");
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
      step("idle", C_NONE, 2'b00, 2'b00, 1'b0);

      // Forwarding
      mem_rd = 5'd5; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1; ex_rs1 = 5'd5;
      step("fwd_mem_pri", C_NONE, 2'b01, 2'b00, 1'b0);
      mem_reg_write = 1'b0;
      step("fwd_wb", C_NONE, 2'b10, 2'b00, 1'b0);
      ex_rs1 = 5'd0; ex_rs2 = 5'd0; wb_rd = 5'd0;
      step("fwd_x0_wb", C_NONE, 2'b00, 2'b00, 1'b0);
      ex_rs1 = 5'd9; ex_rs2 = 5'd7; mem_rd = 5'd7; mem_reg_write = 1'b1; wb_rd = 5'd9;
      step("fwd_split", C_NONE, 2'b10, 2'b01, 1'b0);
      ex_rs1 = 5'd0; ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0;
      step("fwd_x0_mem", C_NONE, 2'b00, 2'b00, 1'b0);

      // Load-use
      clear_inputs(); set_load_use();
      step("lu_hit", C_LU, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      mem_rd = 5'd3; mem_reg_write = 1'b1; ex_rs2 = 5'd3; ex_rd = 5'd4; ex_reg_write = 1'b1;
      de_rs1 = 5'd2; de_uses_rs1 = 1'b1;
      step("lu_release", C_NONE, 2'b00, 2'b01, 1'b0);
      clear_inputs(); set_load_use(); de_uses_rs2 = 1'b0;
      step("lu_unused_rs2", C_NONE, 2'b00, 2'b00, 1'b0);
      clear_inputs(); set_load_use(); ex_rd = 5'd0; de_rs1 = 5'd0;
      step("lu_x0", C_NONE, 2'b00, 2'b00, 1'b0);
      clear_inputs(); set_load_use(); ex_ru_data_src = 2'b00;
      step("lu_not_load", C_NONE, 2'b00, 2'b00, 1'b0);
      clear_inputs(); set_load_use(); ex_br_taken = 1'b1;
      step("lu_with_br", C_BR, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      step("after_br", C_NONE, 2'b00, 2'b00, 1'b0);

      // Memory wait, ack after 4 stalled cycles; branch held until RUN
      dm_req = 1'b1; set_load_use();
      step("mw_run_lu", C_MW, 2'b00, 2'b00, 1'b0);
      clear_inputs(); dm_req = 1'b1;
      step("mw_1", C_MW, 2'b00, 2'b00, 1'b0);
      step("mw_2", C_MW, 2'b00, 2'b00, 1'b0);
      ex_br_taken = 1'b1;
      step("mw_3_br", C_MW, 2'b00, 2'b00, 1'b0);
      dm_ack = 1'b1;
      step("mw_ack", C_NONE, 2'b00, 2'b00, 1'b0);
      dm_req = 1'b0; dm_ack = 1'b0;
      step("mw_br_after", C_BR, 2'b00, 2'b00, 1'b0);
      clear_inputs();
      step("mw_idle", C_NONE, 2'b00, 2'b00, 1'b0);

      // Asynchronous reset in the middle of a memory wait
      dm_req = 1'b1;
      step("rw_1", C_MW, 2'b00, 2'b00, 1'b0);
      step("rw_2", C_MW, 2'b00, 2'b00, 1'b0);
      mem_rd = 5'd5; mem_reg_write = 1'b1; ex_rs1 = 5'd5;
      #3 rst_n = 1'b0;
      #1 check_reset("rst_mid");
      exp_stall = 0; exp_flush = 0;
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs(); ex_br_taken = 1'b1;
      step("rst_run", C_BR, 2'b00, 2'b00, 1'b0);
      clear_inputs();

      // Timeout into HALT; late ack and branches ignored
      dm_req = 1'b1;
      for (int i = 0; i <= int'(MEM_TIMEOUT); i++) begin
         step($sformatf("to_wait%0d", i), C_MW, 2'b00, 2'b00, 1'b0);
      end
      step("to_halt", C_MW, 2'b00, 2'b00, 1'b1);
      dm_ack = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step($sformatf("to_late_ack%0d", i), C_MW, 2'b00, 2'b00, 1'b1);
      end
      dm_req = 1'b0; dm_ack = 1'b0; ex_br_taken = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("to_halt_br%0d", i), C_MW, 2'b00, 2'b00, 1'b1);
      end
      #2;
      check("cnt_saturated", 32'(stall_cnt), CNT_MAX);
      check("flush_after_halt", 32'(flush_cnt), exp_flush);
      rst_n = 1'b0;
      #1 check_reset("rst_halt");
      @(negedge clk);
      rst_n = 1'b1;
      clear_inputs();
      exp_stall = 0; exp_flush = 0;
      step("post_halt_idle", C_NONE, 2'b00, 2'b00, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage RISC-V core.
- Drives the stall, flush and forwarding controls of the IF/DE, DE/EX, EX/MEM and MEM/WB pipeline registers.
- Handles load-use stalls, taken-branch flushes and multi-cycle data-memory waits.
- Detects memory timeouts and keeps performance counters.

Parameters:
- CNT_W, 16, width of the stall and flush performance counters.
- MEM_TIMEOUT, 255, maximum number of wait cycles for a data-memory access before halting.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- de_rs1  in  5  rs1 field of the instruction in DE.
- de_rs2  in  5  rs2 field of the instruction in DE.
- de_uses_rs1  in  1  the DE instruction reads rs1.
- de_uses_rs2  in  1  the DE instruction reads rs2.
- ex_rs1  in  5  rs1 of the instruction in EX.
- ex_rs2  in  5  rs2 of the instruction in EX.
- ex_rd  in  5  rd of the instruction in EX.
- ex_reg_write  in  1  the EX instruction writes a register.
- ex_ru_data_src  in  2  EX write-back source; 2'b01 means load.
- mem_rd  in  5  rd of the instruction in MEM.
- mem_reg_write  in  1  the MEM instruction writes a register.
- wb_rd  in  5  rd of the instruction in WB.
- wb_reg_write  in  1  the WB instruction writes a register.
- ex_br_taken  in  1  branch or jump resolved taken in EX.
- dm_req  in  1  the MEM stage is accessing data memory.
- dm_ack  in  1  data memory completes the access this cycle.
- pc_stall  out  1  hold the PC.
- if_de_stall  out  1  hold IF/DE.
- if_de_flush  out  1  load NOP into IF/DE.
- de_ex_stall  out  1  hold DE/EX.
- de_ex_flush  out  1  load bubble into DE/EX (all control fields zero).
- ex_mem_stall  out  1  hold EX/MEM.
- mem_wb_flush  out  1  load bubble into MEM/WB.
- fwd_a_sel  out  2  ALU operand A source: 00 RS1Out, 01 MEM result, 10 WB result.
- fwd_b_sel  out  2  ALU operand B source, same encoding as fwd_a_sel.
- stall_cnt  out  CNT_W  cycles with pc_stall asserted.
- flush_cnt  out  CNT_W  cycles with if_de_flush asserted.
- mem_timeout  out  1  sticky flag: data-memory timeout occurred.

Behaviour:
- State machine: RUN, MEM_WAIT, HALT. The state register and counters reset asynchronously.
- Control outputs are combinational from the current state and inputs.
- Reset values (while rst_n=0):
  - state=RUN, stall_cnt=0, flush_cnt=0, mem_timeout=0, wait_cnt=0.
  - All stall and flush outputs 0; fwd selects 00.
- Forwarding (every state):
  - fwd_a_sel=01 if mem_reg_write, mem_rd!=0 and mem_rd==ex_rs1.
  - Otherwise fwd_a_sel=10 if wb_reg_write, wb_rd!=0 and wb_rd==ex_rs1.
  - Otherwise 00. MEM has priority over WB.
  - fwd_b_sel is identical, using ex_rs2.
- Memory wait (condition M = dm_req && !dm_ack):
  - In RUN, M asserts pc_stall, if_de_stall, de_ex_stall, ex_mem_stall and mem_wb_flush in the same cycle.
  - Next state is MEM_WAIT; wait_cnt is set to 1.
  - In MEM_WAIT, the same five outputs are asserted while !dm_ack, and wait_cnt increments each cycle.
  - In MEM_WAIT, dm_ack deasserts all stalls that cycle; next state is RUN and wait_cnt is cleared.
  - In MEM_WAIT, !dm_ack with wait_cnt==MEM_TIMEOUT: next state is HALT.
- HALT:
  - Five memory-wait outputs held asserted; mem_timeout=1.
  - Left only by reset.
- Branch flush: in RUN with !M and ex_br_taken, assert if_de_flush and de_ex_flush for 1 cycle. No stalls.
- Load-use: in RUN with !M, !ex_br_taken, ex_ru_data_src==2'b01, ex_reg_write, ex_rd!=0, and ex_rd matching (de_uses_rs1 && de_rs1) or (de_uses_rs2 && de_rs2):
  - Assert pc_stall, if_de_stall and de_ex_flush for exactly 1 cycle.
  - Re-evaluated the next cycle; it clears naturally once the load reaches MEM.
- Priority: memory wait > branch flush > load-use. A taken branch with a load-use hazard flushes only; no stall.
- A branch held in EX during MEM_WAIT is acted on in the first RUN cycle after the ack.
- Counters:
  - stall_cnt increments on every clock edge where pc_stall=1.
  - flush_cnt increments on every clock edge where if_de_flush=1.
  - Both saturate at 2^CNT_W-1.
- x0 never creates a hazard or forwarding.

Test Plan:
- Reset check: pulse rst_n low mid-MEM_WAIT -> all outputs 0 and state RUN immediately (asynchronous); counters 0.
- Forwarding: mem_rd=5 and wb_rd=5 both writing, ex_rs1=5 -> fwd_a_sel=01; drop mem_reg_write -> 10; ex_rs2=0 with wb_rd=0 -> fwd_b_sel=00.
- Load-use: EX lw x3 (ru_data_src=01), DE add uses rs2=x3 -> pc_stall=if_de_stall=de_ex_flush=1 for exactly 1 cycle; stall_cnt=1.
- Load-use with ex_br_taken=1 in the same cycle -> if_de_flush=de_ex_flush=1, pc_stall=0, flush_cnt=1.
- Memory wait: dm_req=1, dm_ack arrives after 4 cycles -> 4 stall cycles (pc, IF/DE, DE/EX, EX/MEM stalled; mem_wb_flush=1); released on the ack cycle; stall_cnt=4.
- Timeout: MEM_TIMEOUT=8, dm_req=1, no ack -> HALT after wait_cnt reaches 8; mem_timeout=1 and stalls persist; a late dm_ack has no effect until reset.
